// File: rtl/psg_tone_noise.sv
// Three-channel PSG tone generator with a shared 17-bit LFSR noise source and mixer.
// Register file R0-R7 with registered readback; all counting is gated by psg_en.
module psg_tone_noise (
  input  logic       clk_peripheral,
  input  logic       reset,
  input  logic       psg_en,
  input  logic       reg_wr,
  input  logic [3:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic [7:0] reg_dout,
  output logic [2:0] tone,
  output logic       noise,
  output logic [2:0] chan
);

  logic [7:0]  tone_fine   [3];
  logic [3:0]  tone_coarse [3];
  logic [4:0]  noise_period;
  logic [7:0]  mixer;

  logic [11:0] tone_cnt    [3];
  logic [11:0] tone_eff    [3];
  logic [12:0] tone_inc    [3];
  logic [2:0]  tone_wrap;

  logic [4:0]  noise_cnt;
  logic [4:0]  noise_eff;
  logic [5:0]  noise_inc;
  logic        noise_wrap;
  logic        noise_pre;
  logic [16:0] lfsr;

  logic [7:0]  rd_data;

  // Period 0 behaves as 1; the >= compare also catches a period lowered below the count.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      tone_eff[i]  = ({tone_coarse[i], tone_fine[i]} == 12'd0) ? 12'd1
                                                               : {tone_coarse[i], tone_fine[i]};
      tone_inc[i]  = {1'b0, tone_cnt[i]} + 13'd1;
      tone_wrap[i] = (tone_inc[i] >= {1'b0, tone_eff[i]});
    end
    noise_eff  = (noise_period == 5'd0) ? 5'd1 : noise_period;
    noise_inc  = {1'b0, noise_cnt} + 6'd1;
    noise_wrap = (noise_inc >= {1'b0, noise_eff});
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      4'd0:    rd_data = tone_fine[0];
      4'd1:    rd_data = {4'h0, tone_coarse[0]};
      4'd2:    rd_data = tone_fine[1];
      4'd3:    rd_data = {4'h0, tone_coarse[1]};
      4'd4:    rd_data = tone_fine[2];
      4'd5:    rd_data = {4'h0, tone_coarse[2]};
      4'd6:    rd_data = {3'b000, noise_period};
      4'd7:    rd_data = mixer;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        tone_fine[i]   <= '0;
        tone_coarse[i] <= '0;
        tone_cnt[i]    <= '0;
      end
      noise_period <= '0;
      mixer        <= '0;
      tone         <= '0;
      noise_cnt    <= '0;
      noise_pre    <= 1'b0;
      lfsr         <= 17'h00001;
      reg_dout     <= '0;
    end else begin
      reg_dout <= rd_data;

      if (reg_wr) begin
        case (reg_addr)
          4'd0:    tone_fine[0]   <= reg_din;
          4'd1:    tone_coarse[0] <= reg_din[3:0];
          4'd2:    tone_fine[1]   <= reg_din;
          4'd3:    tone_coarse[1] <= reg_din[3:0];
          4'd4:    tone_fine[2]   <= reg_din;
          4'd5:    tone_coarse[2] <= reg_din[3:0];
          4'd6:    noise_period   <= reg_din[4:0];
          4'd7:    mixer          <= reg_din;
          default: ;
        endcase
      end

      if (psg_en) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (tone_wrap[i]) begin
            tone_cnt[i] <= '0;
            tone[i]     <= ~tone[i];
          end else begin
            tone_cnt[i] <= tone_inc[i][11:0];
          end
        end

        // Noise runs at half the strobe rate: it advances only when the prescaler was 1.
        noise_pre <= ~noise_pre;
        if (noise_pre) begin
          if (noise_wrap) begin
            noise_cnt <= '0;
            lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
          end else begin
            noise_cnt <= noise_inc[4:0];
          end
        end
      end
    end
  end

  assign noise = lfsr[0];

  always_comb begin
    chan = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      chan[i] = (tone[i] | mixer[i]) & (noise | mixer[i+3]);
    end
  end

endmodule

// File: tb/tb_psg_tone_noise.sv
// Self-checking bench for psg_tone_noise: directed scenarios plus randomized traffic,
// all compared every cycle against an arithmetic model of the register/tone/noise rules.
module tb_psg_tone_noise;

  logic       clk_peripheral = 1'b0;
  logic       reset;
  logic       psg_en;
  logic       reg_wr;
  logic [3:0] reg_addr;
  logic [7:0] reg_din;
  logic [7:0] reg_dout;
  logic [2:0] tone;
  logic       noise;
  logic [2:0] chan;

  psg_tone_noise dut (
    .clk_peripheral (clk_peripheral),
    .reset          (reset),
    .psg_en         (psg_en),
    .reg_wr         (reg_wr),
    .reg_addr       (reg_addr),
    .reg_din        (reg_din),
    .reg_dout       (reg_dout),
    .tone           (tone),
    .noise          (noise),
    .chan           (chan)
  );

  always #5 clk_peripheral = ~clk_peripheral;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: plain integers holding the architectural values.
  int m_reg  [8];
  int m_cnt  [3];
  int m_tone [3];
  int m_ncnt;
  int m_pre;
  int m_lfsr;
  int m_dout;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int readback(input int a);
    if (a == 1 || a == 3 || a == 5) return m_reg[a] & 'h0F;
    if (a == 6)                     return m_reg[6] & 'h1F;
    if (a <= 7)                     return m_reg[a] & 'hFF;
    return 0;
  endfunction

  function automatic int lfsr_next(input int s);
    return (s >> 1) | (((s ^ (s >> 3)) & 1) << 16);
  endfunction

  task automatic model_step();
    int rb;
    int c;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_tone[i] = 0; end
      m_ncnt = 0; m_pre = 0; m_lfsr = 1; m_dout = 0;
      return;
    end
    rb = readback(int'(reg_addr));
    if (psg_en) begin
      for (int i = 0; i < 3; i++) begin
        c = m_cnt[i] + 1;
        if (c >= eff(((m_reg[2*i+1] & 'h0F) * 256) + m_reg[2*i])) begin
          m_cnt[i]  = 0;
          m_tone[i] = 1 - m_tone[i];
        end else begin
          m_cnt[i] = c;
        end
      end
      if (m_pre == 1) begin
        c = m_ncnt + 1;
        if (c >= eff(m_reg[6] & 'h1F)) begin
          m_ncnt = 0;
          m_lfsr = lfsr_next(m_lfsr);
        end else begin
          m_ncnt = c;
        end
      end
      m_pre = 1 - m_pre;
    end
    if (reg_wr && reg_addr <= 4'd7) m_reg[reg_addr] = int'(reg_din);
    m_dout = rb;
  endtask

  function automatic int exp_tone();
    return m_tone[0] + 2 * m_tone[1] + 4 * m_tone[2];
  endfunction

  function automatic int exp_chan();
    int r;
    int t;
    int n;
    r = 0;
    for (int i = 0; i < 3; i++) begin
      t = m_tone[i] | ((m_reg[7] >> i) & 1);
      n = (m_lfsr & 1) | ((m_reg[7] >> (i + 3)) & 1);
      r = r | ((t & n) << i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, update the model at the edge, compare at the following falling edge.
  task automatic cyc(input logic en, input logic wr, input logic [3:0] a,
                     input logic [7:0] d, input logic rst);
    psg_en = en; reg_wr = wr; reg_addr = a; reg_din = d; reset = rst;
    @(posedge clk_peripheral);
    model_step();
    @(negedge clk_peripheral);
    chk("tone",     int'(tone),     exp_tone());
    chk("noise",    int'(noise),    m_lfsr & 1);
    chk("chan",     int'(chan),     exp_chan());
    chk("reg_dout", int'(reg_dout), m_dout);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0);
  endtask

  initial begin
    int k;
    int prev;
    int s;
    logic [3:0] ra;
    logic [7:0] rd;

    psg_en = 0; reg_wr = 0; reg_addr = 0; reg_din = 0; reset = 1;
    @(negedge clk_peripheral);

    // Reset state
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("rst_tone",  int'(tone),  0);
    chk("rst_noise", int'(noise), 1);
    chk("rst_chan",  int'(chan),  0);
    chk("rst_dout",  int'(reg_dout), 0);

    // Period 1 then period 0: tone A toggles on every strobe
    wr(4'd0, 8'h01);
    k = 0;
    for (int j = 0; j < 12; j++) begin
      if (j == 8) wr(4'd0, 8'h00);
      for (int q = 0; q < 15; q++) cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
      k++;
      chk("a_toggle", int'(tone[0]), k % 2);
    end

    // Tone B period 4, then lower to 2 while the count sits at 3
    wr(4'd2, 8'h04);
    wr(4'd3, 8'h00);
    for (int j = 0; j < 16 && m_cnt[1] != 3; j++) cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("b_cnt3_reached", m_cnt[1], 3);
    wr(4'd2, 8'h02);
    prev = m_tone[1];
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("b_wrap_toggle", int'(tone[1]), 1 - prev);
    chk("b_wrap_cnt", m_cnt[1], 0);
    for (int j = 0; j < 20; j++) cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);

    // Noise period 1: shift on every second strobe
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    wr(4'd6, 8'h01);
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("noise_first_hold", int'(noise), 1);
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("lfsr_first_shift", m_lfsr, 'h10000);
    chk("noise_first_shift", int'(noise), 0);
    s = 1; k = 0;
    do begin s = lfsr_next(s); k++; end while (s != 1 && k < 200000);
    chk("lfsr_period", k, 131071);
    for (int j = 0; j < 300; j++) cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);

    // Mixer
    wr(4'd0, 8'h03);
    wr(4'd7, 8'h38);
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
      chk("mix_tone_only", int'(chan), exp_tone());
    end
    wr(4'd7, 8'h07);
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
      chk("mix_noise_only", int'(chan), 7 * (m_lfsr & 1));
    end
    wr(4'd7, 8'h3F);
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("mix_all_off", int'(chan), 7);

    // Readback masking and latency
    wr(4'd1, 8'hFF);
    wr(4'd6, 8'hFF);
    cyc(1'b0, 1'b0, 4'd1, 8'h00, 1'b0);
    chk("rd_r1", int'(reg_dout), 'h0F);
    cyc(1'b0, 1'b0, 4'd6, 8'h00, 1'b0);
    chk("rd_r6", int'(reg_dout), 'h1F);
    cyc(1'b0, 1'b0, 4'd9, 8'h00, 1'b0);
    chk("rd_r9", int'(reg_dout), 'h00);
    wr(4'd9, 8'hAA);
    cyc(1'b0, 1'b0, 4'd7, 8'h00, 1'b0);
    chk("rd_r7", int'(reg_dout), 'h3F);

    // Reset wins over a coincident write and strobe mid-count
    wr(4'd1, 8'h00);
    wr(4'd0, 8'h05);
    for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 4'd0, 8'h55, 1'b1);
    chk("rstw_tone",  int'(tone),  0);
    chk("rstw_noise", int'(noise), 1);
    chk("rstw_chan",  int'(chan),  0);
    chk("rstw_dout",  int'(reg_dout), 0);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("rstw_discard", int'(reg_dout), 0);

    // Randomized traffic
    for (int j = 0; j < 20000; j++) begin
      ra = 4'($urandom_range(0, 15));
      rd = 8'($urandom_range(0, 255));
      if ((ra == 4'd1 || ra == 4'd3 || ra == 4'd5) && ($urandom % 4 != 0)) rd = rd & 8'hF0;
      if ((ra == 4'd0 || ra == 4'd2 || ra == 4'd4) && ($urandom % 2 == 0)) rd = rd & 8'h0F;
      cyc(1'($urandom % 2 == 0), 1'($urandom % 6 == 0), ra, rd, 1'($urandom % 3000 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psg_tone_noise.md
PSG_TONE_NOISE -- requirements
Module: psg_tone_noise

Interface
REQ-001 SHALL have port: clk_peripheral  input  1  peripheral clock; all logic on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: psg_en  input  1  one-cycle clock-enable strobe from the PSG prescaler, nominally 1 in 16 clk_peripheral cycles.
REQ-004 SHALL have port: reg_wr  input  1  register write strobe, one cycle.
REQ-005 SHALL have port: reg_addr  input  4  register index 0-15.
REQ-006 SHALL have port: reg_din  input  8  write data.
REQ-007 SHALL have port: reg_dout  output  8  registered readback of register reg_addr.
REQ-008 SHALL have port: tone  output  3  tone square waves, bit0=A, bit1=B, bit2=C.
REQ-009 SHALL have port: noise  output  1  noise bit.
REQ-010 SHALL have port: chan  output  3  mixed channel bits A/B/C.

Function
REQ-011 SHALL hold registers R0-R7: R0/R1 = A fine/coarse, R2/R3 = B, R4/R5 = C, R6 = noise period, R7 = mixer; 12-bit tone period = {R(2n+1)[3:0], R(2n)}; 5-bit noise period = R6[4:0].
REQ-012 SHALL store reg_din into the addressed register on a cycle with reg_wr=1 and reg_addr<=7; addresses 8-15 SHALL be ignored.
REQ-013 SHALL drive reg_dout one cycle after reg_addr: R1/R3/R5 with bits[7:4]=0, R6 with bits[7:5]=0, R7 full 8 bits, addresses 8-15 as 8'h00.
REQ-014 SHALL do all counting only on cycles with psg_en=1; with psg_en=0 every counter, tone, prescaler and LFSR SHALL hold.
REQ-015 SHALL keep a 12-bit counter per tone channel; effective period P = programmed period, with 0 treated as 1.
REQ-016 SHALL, on each psg_en, compute cnt+1; if cnt+1 >= P, set cnt to 0 and invert that channel's tone bit, else set cnt to cnt+1; the tone period is 2*P psg_en strobes.
REQ-017 SHALL wrap at the next psg_en via the >= compare when a period is lowered below the current count.
REQ-018 SHALL make a register write coincident with psg_en visible from the next cycle; the strobe uses the pre-write value.
REQ-019 SHALL keep a 1-bit noise prescaler that toggles on every psg_en; the noise counter advances only on psg_en when the prescaler is 1 before toggling.
REQ-020 SHALL treat noise period 0 as 1 and apply the REQ-016 compare rule to the 5-bit noise counter; on wrap, shift the 17-bit LFSR right, with new bit16 = lfsr[0] XOR lfsr[3].
REQ-021 SHALL drive noise = lfsr[0].
REQ-022 SHALL drive chan[n] = (tone[n] | R7[n]) & (noise | R7[n+3]); R7 bits are active-low enables, R7[7:6] are stored only.
REQ-023 SHALL compute chan combinationally from registered tone, noise and R7.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, clear R0-R7, all counters, tone, prescaler and reg_dout to 0, and set LFSR to 17'h00001; reset SHALL override reg_wr and psg_en in the same cycle.
REQ-025 SHALL give, after reset, tone=3'b000, noise=1 and chan=3'b000.
REQ-026 SHALL abandon any partial count when reset is asserted mid-operation; counting restarts from 0 at the first psg_en after reset is released.

Verification
REQ-027 SHALL cover: R0=0x01, psg_en every 16 cycles -> tone[0] toggles on every psg_en (32-cycle period); then R0=0x00 -> identical behaviour.
REQ-028 SHALL cover: R2=0x04, R3=0x00 -> tone[1] toggles every 4th psg_en; then write R2=0x02 when cnt=3 -> toggle and wrap at the next psg_en.
REQ-029 SHALL cover: R6=0x01 after reset -> LFSR shifts every 2nd psg_en, first shift gives 17'h10000 and noise=0; 2^17-1 shifts return the LFSR to 17'h00001.
REQ-030 SHALL cover: R7=0x38 -> chan==tone; R7=0x07 -> chan=={3{noise}}; R7=0x3F -> chan=3'b111.
REQ-031 SHALL cover: write R1=0xFF, R6=0xFF, then read addr 1, 6, 9 -> reg_dout 0x0F, 0x1F, 0x00, each one cycle after the address is presented.
REQ-032 SHALL cover: reset asserted with reg_wr=1 and psg_en=1 mid-count -> all state at its reset value next cycle and the write is discarded.
